// File: rtl/dcf77_frame_decoder.sv
// DCF77 minute-frame assembler: collects second bits between minute marks, validates the frame
// and publishes registered BCD date/time. Define DCF77_LEAP_SECOND_EN to accept 60-bit leap-second frames.
module dcf77_frame_decoder #(
   parameter int FRAME_BITS = 59
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bit_valid,
   input  logic        bit_value,
   input  logic        minute_mark,
   output logic        frame_valid,
   output logic        frame_error,
   output logic        synced,
   output logic [13:0] broadcast,
   output logic        r,
   output logic        a1,
   output logic        z1,
   output logic        z2,
   output logic        a2,
   output logic        p1,
   output logic        p2,
   output logic        p3,
   output logic [7:0]  minute,
   output logic [7:0]  hour,
   output logic [7:0]  day,
   output logic [7:0]  month,
   output logic [7:0]  year,
   output logic [2:0]  day_of_week
);

`ifdef DCF77_LEAP_SECOND_EN
   localparam int SR_W = FRAME_BITS + 1;
`else
   localparam int SR_W = FRAME_BITS;
`endif
   localparam int CNT_W = $clog2(FRAME_BITS + 2);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      OVFL = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [SR_W-1:0]   sr_q, sr_d;
   logic              synced_q, synced_d;
   logic              frame_valid_q, frame_valid_d;
   logic              frame_error_q, frame_error_d;
   logic [13:0]       broadcast_q, broadcast_d;
   logic [7:0]        flags_q, flags_d;
   logic [7:0]        minute_q, minute_d;
   logic [7:0]        hour_q, hour_d;
   logic [7:0]        day_q, day_d;
   logic [7:0]        month_q, month_d;
   logic [7:0]        year_q, year_d;
   logic [2:0]        dow_q, dow_d;

   logic [CNT_W-1:0]  bit_limit;
   logic              len_ok;
   logic              marks_ok;
   logic              parity_ok;
   logic              frame_ok;
   logic              accept_bit;

   // A leap-second announcement (a2) stretches the allowed frame by one bit.
   always_comb begin
      bit_limit = CNT_W'(FRAME_BITS);
      len_ok    = (cnt_q == CNT_W'(FRAME_BITS));
`ifdef DCF77_LEAP_SECOND_EN
      if (sr_q[19]) begin
         bit_limit = CNT_W'(FRAME_BITS + 1);
      end
      if ((cnt_q == CNT_W'(FRAME_BITS + 1)) && sr_q[19] && !sr_q[FRAME_BITS]) begin
         len_ok = 1'b1;
      end
`endif
   end

   always_comb begin
      marks_ok   = !sr_q[0] && sr_q[20];
      parity_ok  = !(^sr_q[28:21]) && !(^sr_q[35:29]) && !(^sr_q[58:36]);
      frame_ok   = (state_q == RECV) && len_ok && marks_ok && parity_ok;
      accept_bit = (state_q == RECV) && bit_valid && (cnt_q != bit_limit);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (minute_mark) begin
         state_d = RECV;
      end else begin
         case (state_q)
            RECV: begin
               if (bit_valid && (cnt_q == bit_limit)) begin
                  state_d = OVFL;
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   // A bit arriving together with a minute mark belongs to the new frame.
   always_comb begin
      cnt_d = cnt_q;
      sr_d  = sr_q;
      if (minute_mark) begin
         cnt_d = '0;
         sr_d  = '0;
         if (bit_valid) begin
            sr_d[0] = bit_value;
            cnt_d   = CNT_W'(1);
         end
      end else if (accept_bit) begin
         sr_d[cnt_q] = bit_value;
         cnt_d       = cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      synced_d      = synced_q | minute_mark;
      frame_valid_d = minute_mark && frame_ok;
      frame_error_d = minute_mark && (state_q != IDLE) && !frame_ok;
      broadcast_d   = broadcast_q;
      flags_d       = flags_q;
      minute_d      = minute_q;
      hour_d        = hour_q;
      day_d         = day_q;
      month_d       = month_q;
      year_d        = year_q;
      dow_d         = dow_q;
      if (frame_valid_d) begin
         broadcast_d = sr_q[14:1];
         flags_d     = {sr_q[15], sr_q[16], sr_q[17], sr_q[18], sr_q[19],
                        sr_q[28], sr_q[35], sr_q[58]};
         minute_d    = {1'b0, sr_q[27:21]};
         hour_d      = {2'b00, sr_q[34:29]};
         day_d       = {2'b00, sr_q[41:36]};
         dow_d       = sr_q[44:42];
         month_d     = {3'b000, sr_q[49:45]};
         year_d      = sr_q[57:50];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q         <= '0;
         sr_q          <= '0;
         synced_q      <= 1'b0;
         frame_valid_q <= 1'b0;
         frame_error_q <= 1'b0;
         broadcast_q   <= '0;
         flags_q       <= '0;
         minute_q      <= '0;
         hour_q        <= '0;
         day_q         <= '0;
         month_q       <= '0;
         year_q        <= '0;
         dow_q         <= '0;
      end else begin
         cnt_q         <= cnt_d;
         sr_q          <= sr_d;
         synced_q      <= synced_d;
         frame_valid_q <= frame_valid_d;
         frame_error_q <= frame_error_d;
         broadcast_q   <= broadcast_d;
         flags_q       <= flags_d;
         minute_q      <= minute_d;
         hour_q        <= hour_d;
         day_q         <= day_d;
         month_q       <= month_d;
         year_q        <= year_d;
         dow_q         <= dow_d;
      end
   end

   assign frame_valid = frame_valid_q;
   assign frame_error = frame_error_q;
   assign synced      = synced_q;
   assign broadcast   = broadcast_q;
   assign {r, a1, z1, z2, a2, p1, p2, p3} = flags_q;
   assign minute      = minute_q;
   assign hour        = hour_q;
   assign day         = day_q;
   assign month       = month_q;
   assign year        = year_q;
   assign day_of_week = dow_q;

endmodule

// File: tb/tb_dcf77_frame_decoder.sv
// Scoreboard bench for dcf77_frame_decoder: a frame-level model predicts each minute-mark verdict,
// a separate monitor compares DUT pulses and outputs against the queued predictions.
module tb_dcf77_frame_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        bit_valid;
   logic        bit_value;
   logic        minute_mark;
   logic        frame_valid;
   logic        frame_error;
   logic        synced;
   logic [13:0] broadcast;
   logic        r, a1, z1, z2, a2, p1, p2, p3;
   logic [7:0]  minute, hour, day, month, year;
   logic [2:0]  day_of_week;

   always #5 clk = ~clk;

   dcf77_frame_decoder #(.FRAME_BITS(59)) dut (
      .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_value(bit_value),
      .minute_mark(minute_mark), .frame_valid(frame_valid), .frame_error(frame_error),
      .synced(synced), .broadcast(broadcast), .r(r), .a1(a1), .z1(z1), .z2(z2), .a2(a2),
      .p1(p1), .p2(p2), .p3(p3), .minute(minute), .hour(hour), .day(day), .month(month),
      .year(year), .day_of_week(day_of_week)
   );

   typedef struct {
      bit          ok;
      logic [64:0] fields;
   } exp_t;

   int          tests = 0;
   int          fails = 0;
   exp_t        expq[$];
   bit          rx[$];
   bit          frame[$];
   bit          model_synced = 1'b0;
   logic [64:0] held = '0;

   function automatic logic [64:0] dut_fields();
      return {broadcast, r, a1, z1, z2, a2, p1, p2, p3,
              minute, hour, day, day_of_week, month, year};
   endfunction

   function automatic logic [7:0] to_bcd(input int v);
      return 8'((v / 10) * 16 + (v % 10));
   endfunction

   function automatic bit even_ones(input bit f[$], input int lo, input int hi);
      int ones;
      ones = 0;
      for (int i = lo; i <= hi; i++) ones += int'(f[i]);
      return (ones % 2) == 0;
   endfunction

   // Verdict from the frame's rules: length, fixed marker bits, three parity groups.
   function automatic bit model_ok(input bit f[$]);
      int n;
      bit len_ok;
      n      = f.size();
      len_ok = (n == 59);
`ifdef DCF77_LEAP_SECOND_EN
      if (n == 60 && f[19] && !f[59]) len_ok = 1'b1;
`endif
      if (!len_ok) return 1'b0;
      if (f[0] || !f[20]) return 1'b0;
      return even_ones(f, 21, 28) && even_ones(f, 29, 35) && even_ones(f, 36, 58);
   endfunction

   function automatic logic [64:0] decode(input bit f[$]);
      logic [13:0] bc;
      logic [7:0]  fl, mn, hr, dy, mo, yr;
      logic [2:0]  dw;
      bc = '0; mn = '0; hr = '0; dy = '0; mo = '0; yr = '0; dw = '0;
      for (int i = 0; i < 14; i++) bc[i] = f[1 + i];
      fl = {f[15], f[16], f[17], f[18], f[19], f[28], f[35], f[58]};
      for (int i = 0; i < 7; i++) mn[i] = f[21 + i];
      for (int i = 0; i < 6; i++) hr[i] = f[29 + i];
      for (int i = 0; i < 6; i++) dy[i] = f[36 + i];
      for (int i = 0; i < 3; i++) dw[i] = f[42 + i];
      for (int i = 0; i < 5; i++) mo[i] = f[45 + i];
      for (int i = 0; i < 8; i++) yr[i] = f[50 + i];
      return {bc, fl, mn, hr, dy, dw, mo, yr};
   endfunction

   task automatic checkOutput(input string name, input logic [64:0] actual, input logic [64:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // One cycle of input activity; the model is updated at the moment of issue.
   task automatic applyStimulus(input bit bv, input bit bval, input bit mm);
      exp_t e;
      bit_valid   = bv;
      bit_value   = bval;
      minute_mark = mm;
      if (mm) begin
         if (model_synced) begin
            e.ok = model_ok(rx);
            if (e.ok) held = decode(rx);
            e.fields = held;
            expq.push_back(e);
         end
         model_synced = 1'b1;
         rx.delete();
         if (bv) rx.push_back(bval);
      end else if (bv && model_synced) begin
         rx.push_back(bval);
      end
      @(posedge clk); #1;
      bit_valid   = 1'b0;
      bit_value   = 1'b0;
      minute_mark = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic build_frame(input int mn, input int hr, input int dy, input int dw,
                              input int mo, input int yr, input bit a2v,
                              input bit add_extra, input bit extra_bit);
      logic [7:0] bm, bh, bd, bmo, by;
      logic [2:0] bw;
      bm = to_bcd(mn); bh = to_bcd(hr); bd = to_bcd(dy); bmo = to_bcd(mo); by = to_bcd(yr);
      bw = 3'(dw);
      frame.delete();
      frame.push_back(1'b0);
      for (int i = 1; i <= 18; i++) frame.push_back(bit'($urandom_range(1, 0)));
      frame.push_back(a2v);
      frame.push_back(1'b1);
      for (int i = 0; i < 7; i++) frame.push_back(bm[i]);
      frame.push_back(^bm[6:0]);
      for (int i = 0; i < 6; i++) frame.push_back(bh[i]);
      frame.push_back(^bh[5:0]);
      for (int i = 0; i < 6; i++) frame.push_back(bd[i]);
      for (int i = 0; i < 3; i++) frame.push_back(bw[i]);
      for (int i = 0; i < 5; i++) frame.push_back(bmo[i]);
      for (int i = 0; i < 8; i++) frame.push_back(by[i]);
      frame.push_back(^{bd[5:0], bw, bmo[4:0], by});
      if (add_extra) frame.push_back(extra_bit);
   endtask

   task automatic send_frame(input int start, input int stop);
      for (int i = start; i < stop; i++) begin
         applyStimulus(1'b1, frame[i], 1'b0);
         idle($urandom_range(2, 0));
      end
   endtask

   task automatic build_random(input bit a2v, input bit add_extra, input bit extra_bit);
      build_frame($urandom_range(59, 0), $urandom_range(23, 0), $urandom_range(31, 1),
                  $urandom_range(7, 1), $urandom_range(12, 1), $urandom_range(99, 0),
                  a2v, add_extra, extra_bit);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      model_synced = 1'b0;
      rx.delete();
      held = '0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (frame_valid || frame_error) begin
            if (expq.size() == 0) begin
               tests++;
               fails++;
               $display("[TB] FAIL unexpected_pulse: got valid=%0b error=%0b expected no pulse",
                        frame_valid, frame_error);
            end else begin
               e = expq.pop_front();
               checkOutput("pulse_kind", {frame_error, frame_valid}, e.ok ? 65'd1 : 65'd2);
               checkOutput("fields", dut_fields(), e.fields);
            end
         end
      end
   end

   initial begin : stimulus
      int kind;
      int idx;
      bit_valid = 1'b0; bit_value = 1'b0; minute_mark = 1'b0;
      do_reset();
      idle(3);
      checkOutput("reset_fields", dut_fields(), 65'd0);
      checkOutput("reset_synced", synced, 1'b0);
      checkOutput("reset_pulses", {frame_valid, frame_error}, 2'b00);
      rst = 1'b1;
      idle(2);

      // Bits before the first mark are ignored.
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("presync_synced", synced, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("sync_synced", synced, 1'b1);

      build_frame(34, 12, 25, 3, 12, 24, 1'b0, 1'b0, 1'b0);
      send_frame(0, 59);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("good_valid", frame_valid, 1'b1);
      checkOutput("good_hour", hour, 8'h12);
      checkOutput("good_minute", minute, 8'h34);
      checkOutput("good_day", day, 8'h25);
      checkOutput("good_dow", day_of_week, 3'd3);
      checkOutput("good_month", month, 8'h12);
      checkOutput("good_year", year, 8'h24);

      frame[28] = !frame[28];
      send_frame(0, 59);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("p1_error", frame_error, 1'b1);
      checkOutput("p1_hold_hour", hour, 8'h12);
      idle(1);
      checkOutput("p1_error_one_cycle", frame_error, 1'b0);

      build_random(1'b0, 1'b0, 1'b0);
      send_frame(0, 58);
      applyStimulus(1'b0, 1'b0, 1'b1);
      send_frame(0, 59);
      applyStimulus(1'b0, 1'b0, 1'b1);

      build_random(1'b1, 1'b1, 1'b0);
      send_frame(0, 60);
      applyStimulus(1'b0, 1'b0, 1'b1);

      build_random(1'b1, 1'b1, 1'b0);
      frame.push_back(1'b0);
      send_frame(0, 61);
      applyStimulus(1'b0, 1'b0, 1'b1);

      // First bit coincident with the mark counts as bit 0 of the new frame.
      build_random(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, frame[0], 1'b1);
      send_frame(1, 59);
      applyStimulus(1'b1, frame[0], 1'b1);
      send_frame(1, 59);
      applyStimulus(1'b0, 1'b0, 1'b1);

      build_random(1'b0, 1'b0, 1'b0);
      send_frame(0, 30);
      do_reset();
      #1;
      checkOutput("midreset_fields", dut_fields(), 65'd0);
      checkOutput("midreset_synced", synced, 1'b0);
      idle(2);
      rst = 1'b1;
      idle(1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("postreset_pulses", {frame_valid, frame_error}, 2'b00);
      checkOutput("postreset_fields", dut_fields(), 65'd0);
      send_frame(0, 59);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("postreset_recv_valid", frame_valid, 1'b1);

      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(5, 0);
         case (kind)
            3: begin
               build_random(1'b0, 1'b0, 1'b0);
               idx = $urandom_range(58, 0);
               frame[idx] = !frame[idx];
            end
            4: begin
               build_random(1'b0, 1'b0, 1'b0);
               if ($urandom_range(1, 0) == 1) frame.push_back(1'b0);
               else void'(frame.pop_back());
            end
            5: build_random(1'b1, 1'b1, bit'($urandom_range(1, 0)));
            default: build_random(bit'($urandom_range(1, 0)), 1'b0, 1'b0);
         endcase
         send_frame(0, frame.size());
         applyStimulus(bit'($urandom_range(1, 0) == 1 && kind == 0), 1'b0, 1'b1);
         idle($urandom_range(3, 0));
         if (rx.size() > 0) begin
            rx.delete();
            applyStimulus(1'b0, 1'b0, 1'b1);
         end
      end

      idle(4);
      checkOutput("scoreboard_drained", 65'(expq.size()), 65'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
